// File: rtl/lsu_dc2w_ctrl.sv
// rtl/lsu_dc2w_ctrl.sv - miss/refill/flush controller for a 2-way write-back data cache
module lsu_dc2w_ctrl #(
  parameter int         IDXW      = 8,
  parameter logic [1:0] UC_REGION = 2'b11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rst_pipe,
  input  logic              req_ld,
  input  logic              req_st,
  input  logic [31:0]       req_adr,
  input  logic              st_commit,
  output logic              dc_hit,
  output logic              dc_hit_way,
  output logic              dc_stall,
  output logic              dc_replay,
  output logic [IDXW-1:0]   ram_radr,
  output logic              ram_rway,
  output logic              ram_ren,
  input  logic [127:0]      ram_rdata,
  output logic [IDXW-1:0]   ram_wadr,
  output logic              ram_wway,
  output logic              ram_wen,
  output logic [127:0]      ram_wdata,
  output logic              dcw_start_rq,
  output logic [31:0]       dcw_in_addr,
  output logic [127:0]      dcw_in_data,
  input  logic              dcw_finish_wresp,
  output logic              dcr_start_rq,
  output logic [31:0]       dcr_rin_addr,
  input  logic [127:0]      rdat_m_data,
  input  logic              rdat_m_valid,
  input  logic              start_dcflush,
  output logic              dcflush_running
);

  localparam int TAGW = 28 - IDXW;
  localparam int SETS = 1 << IDXW;

  typedef enum logic [2:0] {IDLE, WBRD, WBRQ, WBWT, RDRQ, RDWT, DONE, FLSH} state_t;

  state_t            state;
  logic [SETS-1:0]   vld0, vld1, dty0, dty1, lru;
  logic [TAGW-1:0]   tag0 [SETS];
  logic [TAGW-1:0]   tag1 [SETS];
  logic [IDXW-1:0]   vidx;
  logic              vway;
  logic [TAGW-1:0]   rtag;
  logic [TAGW-1:0]   wtag;
  logic [IDXW:0]     fcnt;
  logic              flush_q;
  logic [127:0]      wb_data;

  logic [IDXW-1:0]   req_idx;
  logic [TAGW-1:0]   req_tag;
  logic              cacheable, hit0, hit1, hit, hit_way, miss_idle;
  logic              victim, victim_dirty, commit, fill;
  logic [IDXW-1:0]   f_idx;
  logic              f_way, f_vd, f_last;
  logic              unused_adr_lo;

  assign unused_adr_lo = ^req_adr[3:0];

  assign req_idx   = req_adr[IDXW+3:4];
  assign req_tag   = req_adr[31:IDXW+4];
  assign cacheable = (req_ld | req_st) & (req_adr[31:30] != UC_REGION);
  assign hit0      = cacheable & vld0[req_idx] & (tag0[req_idx] == req_tag);
  assign hit1      = cacheable & vld1[req_idx] & (tag1[req_idx] == req_tag);
  assign hit       = hit0 | hit1;
  // way 0 takes priority if both ways somehow match
  assign hit_way   = ~hit0 & hit1;
  assign miss_idle = (state == IDLE) & cacheable & ~hit;

  // fill an empty way first, otherwise evict the least recently used one
  assign victim       = !vld0[req_idx] ? 1'b0 : (!vld1[req_idx] ? 1'b1 : lru[req_idx]);
  assign victim_dirty = victim ? (vld1[req_idx] & dty1[req_idx]) : (vld0[req_idx] & dty0[req_idx]);

  // flush counter is {index, way}, so both ways of a set are visited back to back
  assign f_idx  = fcnt[IDXW:1];
  assign f_way  = fcnt[0];
  assign f_vd   = f_way ? (vld1[f_idx] & dty1[f_idx]) : (vld0[f_idx] & dty0[f_idx]);
  assign f_last = &fcnt;

  assign commit = st_commit & hit & ((state == IDLE) | (state == DONE));
  assign fill   = (state == RDWT) & rdat_m_valid & ~rst_pipe;

  assign dc_hit          = hit;
  assign dc_hit_way      = hit ? hit_way : vway;
  assign dc_stall        = ((state != IDLE) && (state != DONE)) || miss_idle;
  assign dc_replay       = (state == DONE);
  assign ram_radr        = vidx;
  assign ram_rway        = vway;
  assign ram_ren         = (state == WBRD);
  assign ram_wadr        = vidx;
  assign ram_wway        = vway;
  assign ram_wen         = fill;
  assign ram_wdata       = fill ? rdat_m_data : 128'h0;
  assign dcw_start_rq    = (state == WBRQ);
  assign dcw_in_addr     = {wtag, vidx, 4'h0};
  // RAM data arrives in WBRQ itself; the register holds it for the rest of the write-back
  assign dcw_in_data     = (state == WBRQ) ? ram_rdata : wb_data;
  assign dcr_start_rq    = (state == RDRQ);
  assign dcr_rin_addr    = {rtag, vidx, 4'h0};
  assign dcflush_running = flush_q;

  // tag store: written only on refill, contents are qualified by the valid bits
  always_ff @(posedge clk) begin
    if (fill) begin
      if (vway) tag1[vidx] <= rtag;
      else      tag0[vidx] <= rtag;
    end
  end

  // main FSM with valid/dirty/LRU state, miss latching and the flush walker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      vld0    <= '0; vld1 <= '0; dty0 <= '0; dty1 <= '0; lru <= '0;
      vidx    <= '0; vway <= 1'b0; rtag <= '0; wtag <= '0;
      fcnt    <= '0; flush_q <= 1'b0; wb_data <= '0;
    end else if (rst_pipe) begin
      state   <= IDLE;
      vld0    <= '0; vld1 <= '0; dty0 <= '0; dty1 <= '0; lru <= '0;
      vidx    <= '0; vway <= 1'b0; rtag <= '0; wtag <= '0;
      fcnt    <= '0; flush_q <= 1'b0; wb_data <= '0;
    end else begin
      if (commit) begin
        if (hit_way) dty1[req_idx] <= 1'b1;
        else         dty0[req_idx] <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (hit) lru[req_idx] <= ~hit_way;
          if (miss_idle) begin
            vidx  <= req_idx;
            vway  <= victim;
            rtag  <= req_tag;
            if (victim_dirty) begin
              wtag  <= victim ? tag1[req_idx] : tag0[req_idx];
              state <= WBRD;
            end else begin
              state <= RDRQ;
            end
          end else if (start_dcflush) begin
            fcnt    <= '0;
            flush_q <= 1'b1;
            state   <= FLSH;
          end
        end
        WBRD: state <= WBRQ;
        WBRQ: begin
          wb_data <= ram_rdata;
          state   <= WBWT;
        end
        WBWT: begin
          if (dcw_finish_wresp) begin
            if (flush_q) begin
              if (vway) begin vld1[vidx] <= 1'b0; dty1[vidx] <= 1'b0; end
              else      begin vld0[vidx] <= 1'b0; dty0[vidx] <= 1'b0; end
              fcnt <= fcnt + 1'b1;
              if (f_last) begin
                flush_q <= 1'b0;
                state   <= IDLE;
              end else begin
                state <= FLSH;
              end
            end else begin
              state <= RDRQ;
            end
          end
        end
        RDRQ: state <= RDWT;
        RDWT: begin
          if (rdat_m_valid) begin
            if (vway) begin vld1[vidx] <= 1'b1; dty1[vidx] <= 1'b0; end
            else      begin vld0[vidx] <= 1'b1; dty0[vidx] <= 1'b0; end
            lru[vidx] <= ~vway;
            state     <= DONE;
          end
        end
        DONE: state <= IDLE;
        FLSH: begin
          if (f_vd) begin
            vidx  <= f_idx;
            vway  <= f_way;
            wtag  <= f_way ? tag1[f_idx] : tag0[f_idx];
            state <= WBRD;
          end else begin
            if (f_way) vld1[f_idx] <= 1'b0;
            else       vld0[f_idx] <= 1'b0;
            fcnt <= fcnt + 1'b1;
            if (f_last) begin
              flush_q <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_dc2w_ctrl.md
Name: lsu_dc2w_ctrl

Overview:
- Miss/refill controller for a 2-way set-associative, write-back, write-allocate data cache in the MA stage.
- Successor to the direct-mapped LSU cache controller:
  - index width is parametrised;
  - adds per-set LRU way selection and an uncached-region parameter;
  - flush walks both ways and writes back only dirty lines.
- Sits between the MA-stage load/store path, the 128-bit line data RAM (external, 1-cycle read latency) and the tiny-AXI read/write bus masters.

Parameters:
- IDXW, 8, set index width; sets = 2**IDXW; index = adr[IDXW+3:4]; tag = adr[31:IDXW+4] (TAGW = 28-IDXW).
- UC_REGION, 2'b11, adr[31:30] value marking an uncached access; it never hits or misses.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rst_pipe  in  1  synchronous pipeline reset
- req_ld  in  1  MA-stage load valid
- req_st  in  1  MA-stage store valid
- req_adr  in  32  MA-stage byte address
- st_commit  in  1  store data written into the cache line this cycle; sets dirty
- dc_hit  out  1  cacheable request hits (combinational)
- dc_hit_way  out  1  way of hit; after a fill, way that was filled
- dc_stall  out  1  freeze pipeline
- dc_replay  out  1  one-cycle pulse; MA re-presents the request, which now hits
- ram_radr  out  IDXW  data RAM read index
- ram_rway  out  1  data RAM read way
- ram_ren  out  1  data RAM read enable
- ram_rdata  in  128  data RAM read data; valid the cycle after ram_ren
- ram_wadr  out  IDXW  data RAM write index
- ram_wway  out  1  data RAM write way
- ram_wen  out  1  data RAM write enable
- ram_wdata  out  128  data RAM write data (= bus read data)
- dcw_start_rq  out  1  write-bus request pulse
- dcw_in_addr  out  32  write-back line address, bits [3:0] = 0
- dcw_in_data  out  128  write-back data
- dcw_finish_wresp  in  1  write response received
- dcr_start_rq  out  1  read-bus request pulse
- dcr_rin_addr  out  32  refill line address, bits [3:0] = 0
- rdat_m_data  in  128  refill data
- rdat_m_valid  in  1  refill data valid (single beat)
- start_dcflush  in  1  start flush (pulse)
- dcflush_running  out  1  flush in progress

Behaviour:
- Reset (rst_n low, async) and rst_pipe (sync):
  - state = IDLE; all valid, dirty and LRU bits = 0;
  - all outputs 0, except dcflush_running = 0 and dc_stall = 0.
- rst_pipe mid-miss or mid-flush aborts immediately; an outstanding bus response is ignored.
- Tag/valid/dirty/LRU are held in internal flop arrays, read combinationally at the req_adr index.
- Request definitions:
  - cacheable = (req_ld|req_st) & adr[31:30] != UC_REGION;
  - hit = cacheable & a way is valid with an equal tag;
  - when both ways hit, way 0 wins (cannot occur legally).
- On a hit in IDLE: the LRU bit of the set points to the other way (LRU = ~hit_way).
- Victim selection: invalid way 0, else invalid way 1, else the LRU way. Index, tag and victim way are latched on miss.
- FSM states:
  - IDLE: on cacheable miss, go to WBRD if the victim is valid & dirty, else to RDRQ.
  - WBRD: ram_ren = 1 at the victim set/way for 1 cycle, then WBRQ.
  - WBRQ: dcw_start_rq = 1 for 1 cycle; address = {victim tag, index, 4'h0}; data = ram_rdata, captured in a register. Then WBWT.
  - WBWT: wait for dcw_finish_wresp, then RDRQ.
  - RDRQ: dcr_start_rq = 1 for 1 cycle; address = {req tag, index, 4'h0}. Then RDWT.
  - RDWT: on rdat_m_valid:
    - ram_wen = 1 in the same cycle;
    - the tag is written, valid = 1, dirty = 0;
    - LRU = ~victim way;
    - go to DONE.
  - DONE: dc_replay = 1 for 1 cycle, then IDLE.
- dc_stall = 1 in every state other than IDLE and DONE, and also in IDLE when a cacheable miss is present.
- st_commit sets the dirty bit of the set/way that hit. It is ignored while not in IDLE/DONE.
- Flush:
  - start_dcflush is accepted only in IDLE and is ignored otherwise.
  - A counter walks {index, way} from 0 to 2**(IDXW+1)-1, one entry per cycle.
  - A valid & dirty entry uses the WBRD/WBRQ/WBWT sequence, then clears dirty and resumes.
  - Each visited entry has valid cleared.
  - dcflush_running = 1 from the cycle after start until the cycle after the last entry; dc_stall = 1 throughout.
  - The counter wraps to 0 at end; the FSM returns to IDLE.
- Simultaneous events:
  - rdat_m_valid in IDLE/WBWT is ignored.
  - dcw_finish_wresp and rdat_m_valid never both matter in the same state.
  - start_dcflush together with a miss: the miss wins and the flush is dropped.

Test Plan:
- Cold load 0x0000_1230 (IDXW=8) → RDRQ with dcr_rin_addr=0x0000_1230; after rdat_m_valid → ram_wen at index 0x23, way 0; dc_replay; the replayed load hits way 0.
- Loads 0x0000_1230, then 0x0010_1230 → second fills way 1; a reload of 0x0000_1230 hits way 0 with no bus traffic.
- Ways full, store to way 0 + st_commit, load 0x0010_1230 (way 1 hit, LRU → way 0), then miss 0x0020_1230 → victim way 0 is dirty → dcw_in_addr=0x0000_1230 with the stored data, then refill of way 0.
- Uncached load 0xC000_0000 → dc_hit=0, dc_stall=0, no bus request.
- Flush with 3 dirty lines among 512 entries → exactly 3 dcw_start_rq pulses; afterwards, every access misses.
- rst_pipe asserted in RDWT → IDLE next cycle, no ram_wen, and a later rdat_m_valid is ignored.
